kpscan: RTL

//  Hardware 4x4 keypad scanner, a neighbour of the spio GPIO block. It takes

---
 rtl/kpscan_defs.sv | 22 ++
 rtl/kpfifo.sv | 56 +++++
 rtl/kpscan.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/kpscan_defs.sv
// Shared definitions for the keypad scanner: scanner states and keycode width.
package kpscan_defs;

    localparam int KEYW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Index of the low row; only meaningful when exactly one row is low.
    function automatic logic [1:0] low_row(input logic [3:0] row);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!row[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/kpfifo.sv
// Small synchronous FIFO holding scanned keycodes; push on full drops the data
// unless a pop happens in the same cycle.
module kpfifo #(
    parameter int DW     = 4,
    parameter int LGFLEN = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DW-1:0]     i_data,
    output logic [DW-1:0]     o_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [LGFLEN:0]   o_cnt
);

    localparam int DEPTH = 2 ** LGFLEN;

    logic [DW-1:0]     mem_q [DEPTH];
    logic [LGFLEN-1:0] wr_q, rd_q;
    logic [LGFLEN:0]   cnt_q, cnt_d;
    logic              do_push, do_pop;

    assign o_empty = (cnt_q == '0);
    assign o_full  = (cnt_q == (LGFLEN+1)'(DEPTH));
    assign o_cnt   = cnt_q;
    assign o_data  = mem_q[rd_q];

    assign do_pop  = i_pop & ~o_empty;
    assign do_push = i_push & (~o_full | do_pop);

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
        else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count alone define what is valid.
    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_q] <= i_data;
    end

endmodule

// File: rtl/kpscan.sv
// 4x4 keypad scanner: synchronises rows, debounces, scans columns and queues
// keycodes for a single-register Wishbone slave.
module kpscan
    import kpscan_defs::*;
#(
    parameter int SETTLE_CLKS   = 800,
    parameter int DEBOUNCE_CLKS = 8000,
    parameter int LGFIFO        = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_kp_col,
    input  logic [3:0]  i_kp_row,
    output logic        o_kp_int
);

    localparam int DBW = $clog2(DEBOUNCE_CLKS + 1);
    localparam int SW  = $clog2(SETTLE_CLKS + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CLKS - 1);
    localparam logic [SW-1:0]  ST_LAST = SW'(SETTLE_CLKS - 1);

    state_t          state_q, state_d;
    logic [1:0]      col_q, col_d;
    logic [DBW-1:0]  dbc_q, dbc_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [3:0]      row_m_q, row_s_q;
    logic [2:0]      low_cnt;
    logic            push;
    logic [KEYW-1:0] push_key;

    logic            ack_q, ovfl_q, int_q;
    logic [31:0]     wb_data_q;
    logic            rd, wr, pop;
    logic [KEYW-1:0] fifo_head;
    logic            fifo_full, fifo_empty;
    logic [LGFIFO:0] fifo_cnt;
    logic            unused_ok;

    assign unused_ok = ^{i_wb_cyc, i_wb_data[31:9], i_wb_data[7:0]};
    assign low_cnt   = 3'($countones(~row_s_q));
    assign o_kp_col  = (state_q == ST_SCAN) ? ~(4'b1 << col_q) : 4'h0;

    // NOTE: every output of this block is given a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        dbc_d    = dbc_q;
        settle_d = settle_q;
        push     = 1'b0;
        push_key = '0;
        case (state_q)
            ST_IDLE: begin
                if (row_s_q == 4'hF) dbc_d = '0;
                else if (dbc_q == DB_LAST) begin
                    dbc_d    = '0;
                    col_d    = 2'd0;
                    settle_d = '0;
                    state_d  = ST_SCAN;
                end else dbc_d = dbc_q + 1'b1;
            end
            ST_SCAN: begin
                if (settle_q != ST_LAST) settle_d = settle_q + 1'b1;
                else begin
                    settle_d = '0;
                    if (low_cnt == 3'd1) begin
                        push     = 1'b1;
                        push_key = {col_q, low_row(row_s_q)};
                        state_d  = ST_HOLD;
                    end else if (low_cnt == 3'd0) begin
                        // Key vanished before its column was reached: nothing to report.
                        if (col_q == 2'd3) state_d = ST_HOLD;
                        else col_d = col_q + 1'b1;
                    end else state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (row_s_q != 4'hF) dbc_d = '0;
                else if (dbc_q == DB_LAST) begin
                    dbc_d   = '0;
                    state_d = ST_IDLE;
                end else dbc_d = dbc_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rd  = i_wb_stb & ~i_wb_we;
    assign wr  = i_wb_stb & i_wb_we;
    assign pop = rd & ~fifo_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            col_q     <= 2'd0;
            dbc_q     <= '0;
            settle_q  <= '0;
            row_m_q   <= 4'hF;
            row_s_q   <= 4'hF;
            ack_q     <= 1'b0;
            wb_data_q <= '0;
            ovfl_q    <= 1'b0;
            int_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            dbc_q    <= dbc_d;
            settle_q <= settle_d;
            row_m_q  <= i_kp_row;
            row_s_q  <= row_m_q;
            ack_q    <= i_wb_stb;
            int_q    <= ~fifo_empty;
            if (rd) begin
                wb_data_q <= 32'({ovfl_q, fifo_cnt, ~fifo_empty,
                                  fifo_empty ? {KEYW{1'b0}} : fifo_head});
            end
            // Software clearing the flag takes priority over a simultaneous overflow.
            if (wr && i_wb_data[8]) ovfl_q <= 1'b0;
            else if (push && fifo_full && !pop) ovfl_q <= 1'b1;
        end
    end

    assign o_wb_ack  = ack_q;
    assign o_wb_data = wb_data_q;
    assign o_kp_int  = int_q;

    kpfifo #(
        .DW     (KEYW),
        .LGFLEN (LGFIFO)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_pop   (pop),
        .i_data  (push_key),
        .o_data  (fifo_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_cnt   (fifo_cnt)
    );

endmodule
